// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension execute unit: shift-add multiply, restoring divide.
// Fixed XLEN+2 cycle latency from accept to register-file write strobe, one op in flight.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  kill,
  output logic                  busy,
  output logic                  write_reg,
  output logic [REG_ADDR_W-1:0] write_reg_addr,
  output logic [XLEN-1:0]       write_reg_data,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [2:0]              op_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [XLEN-1:0]         a_q;
  logic [XLEN-1:0]         mag_b_q;
  logic [2*XLEN-1:0]       prod_q;
  logic                    sa_q;
  logic                    sb_q;

  logic                    a_signed;
  logic                    b_signed;
  logic                    sa_in;
  logic                    sb_in;
  logic [XLEN-1:0]         mag_a;
  logic [XLEN-1:0]         mag_b;

  logic [XLEN:0]           mul_sum;
  logic [XLEN:0]           div_part;
  logic                    div_ge;
  logic [XLEN-1:0]         div_rem;
  logic [2*XLEN-1:0]       prod_d;

  logic [2*XLEN-1:0]       prod_neg;
  logic [2*XLEN-1:0]       mul_res;
  logic [XLEN-1:0]         quo;
  logic [XLEN-1:0]         rem;
  logic                    b_zero;
  logic [XLEN-1:0]         result_d;

  assign dbg_state_o = state_q;

  // Operand signedness depends on the op being launched.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
    sa_in = a_signed & op_a[XLEN-1];
    sb_in = b_signed & op_b[XLEN-1];
    mag_a = sa_in ? (~op_a + 1'b1) : op_a;
    mag_b = sb_in ? (~op_b + 1'b1) : op_b;
  end

  // prod_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
               (prod_q[0] ? {1'b0, mag_b_q} : {(XLEN+1){1'b0}});
    div_part = prod_q[2*XLEN-1:XLEN-1];
    div_ge   = (div_part >= {1'b0, mag_b_q});
    div_rem  = div_part[XLEN-1:0] - mag_b_q;
    prod_d   = prod_q;
    if (op_q[2]) begin
      if (div_ge) begin
        prod_d = {div_rem, prod_q[XLEN-2:0], 1'b1};
      end else begin
        prod_d = {div_part[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
      end
    end else begin
      prod_d = {mul_sum, prod_q[XLEN-1:1]};
    end
  end

  // Divide by zero bypasses sign correction and returns the raw dividend as remainder.
  always_comb begin
    prod_neg = ~prod_q + 1'b1;
    mul_res  = (sa_q ^ sb_q) ? prod_neg : prod_q;
    quo      = prod_q[XLEN-1:0];
    rem      = prod_q[2*XLEN-1:XLEN];
    b_zero   = (mag_b_q == {XLEN{1'b0}});
    result_d = {XLEN{1'b0}};
    case (op_q)
      OP_MUL:                        result_d = mul_res[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_d = mul_res[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (b_zero)            result_d = {XLEN{1'b1}};
        else if (sa_q ^ sb_q)  result_d = ~quo + 1'b1;
        else                   result_d = quo;
      end
      default: begin
        if (b_zero)      result_d = a_q;
        else if (sa_q)   result_d = ~rem + 1'b1;
        else             result_d = rem;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      rd_q           <= '0;
      a_q            <= '0;
      mag_b_q        <= '0;
      prod_q         <= '0;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      busy           <= 1'b0;
      write_reg      <= 1'b0;
      write_reg_addr <= '0;
      write_reg_data <= '0;
    end else begin
      write_reg <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !kill) begin
            op_q    <= op;
            rd_q    <= rd_addr;
            a_q     <= op_a;
            mag_b_q <= mag_b;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            prod_q  <= {{XLEN{1'b0}}, mag_a};
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (kill) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          busy    <= 1'b0;
          state_q <= IDLE;
          if (!kill) begin
            write_reg_data <= result_d;
            write_reg_addr <= rd_q;
            write_reg      <= (rd_q != '0);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
